fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard stalls, taken-branch/jr redirects from EX, and j/jal redirects from ID.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/next_pc_sel.sv | 37 +++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and next-PC select encoding for the fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Source of the PC value loaded on the next rising edge
  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_JUMP     = 2'd1,
    SEL_REDIRECT = 2'd2,
    SEL_HOLD     = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority selection (redirect > jump > stall > sequential)
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
  input  logic [3:0]  ifid_pc_hi,
  output logic [31:0] next_pc,
  output pc_sel_t     sel,
  output logic        misaligned
);

  // A redirect from EX beats everything, including a stall, because the
  // instructions behind it are wrong-path. A jump in ID must wait out a stall
  // since it is still sitting in ID and will be re-presented afterwards.
  always_comb begin
    next_pc    = pc;
    sel        = SEL_HOLD;
    misaligned = 1'b0;
    if (redirect_valid) begin
      next_pc    = {redirect_pc[31:2], 2'b00};
      sel        = SEL_REDIRECT;
      misaligned = |redirect_pc[1:0];
    end else if (jump_valid && !stall) begin
      next_pc = {ifid_pc_hi, jump_index, 2'b00};
      sel     = SEL_JUMP;
    end else if (!stall) begin
      next_pc = pc + 32'd4;
      sel     = SEL_SEQ;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, IF/ID register, fetch counter
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 256,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             jump_valid,
  input  logic [25:0]      jump_index,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus4,
  output logic             addr_err,
  output logic [CNT_W-1:0] fetch_count
);

  // 33 bits so a full 4 GiB memory depth still compares correctly
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] next_pc;
  pc_sel_t     sel;
  logic        misaligned;
  logic        in_range;

  assign imem_pc  = pc;
  assign in_range = ({1'b0, pc} < IMEM_BYTES);

  next_pc_sel u_next_pc_sel (
    .pc             (pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .jump_valid     (jump_valid),
    .jump_index     (jump_index),
    .ifid_pc_hi     (ifid_pc_plus4[31:28]),
    .next_pc        (next_pc),
    .sel            (sel),
    .misaligned     (misaligned)
  );

  // Advance PC and load or flush IF/ID according to the selected source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= 32'd0;
      addr_err      <= 1'b0;
      fetch_count   <= '0;
    end else begin
      addr_err <= 1'b0;
      unique case (sel)
        SEL_REDIRECT: begin
          pc         <= next_pc;
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_INSTR;
          addr_err   <= misaligned;
        end
        SEL_JUMP: begin
          pc         <= next_pc;
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_INSTR;
        end
        SEL_SEQ: begin
          pc            <= next_pc;
          ifid_pc_plus4 <= next_pc;
          if (in_range) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imem_instr;
            if (fetch_count != {CNT_W{1'b1}}) begin
              fetch_count <= fetch_count + CNT_W'(1);
            end
          end else begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            addr_err   <= 1'b1;
          end
        end
        SEL_HOLD: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, random run vs model, corner sequences
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        err;
    logic [31:0] cnt;
  } mstate_t;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        jv;
    logic [25:0] ji;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        jump_valid = 1'b0;
  logic [25:0] jump_index = 26'd0;

  logic [31:0] pc_a, imem_a, instr_a, pp4_a, cnt_a;
  logic        v_a, err_a;
  logic [31:0] pc_b, imem_b, instr_b, pp4_b;
  logic [2:0]  cnt_b;
  logic        v_b, err_b;

  int checks = 0;
  int errors = 0;

  mstate_t ma, mb;
  vec_t    vecs[15];

  always #5 clk = ~clk;

  // Memory contents: word at index i is 8c000000 | (i+1)<<16 | (8i+4)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    return {8'h8c, 8'(i + 32'd1), 16'(i * 32'd8 + 32'd4)};
  endfunction

  assign imem_a = mem_word(pc_a);
  assign imem_b = mem_word(pc_b);

  fetch_stage dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .jump_valid(jump_valid), .jump_index(jump_index),
    .imem_pc(pc_a), .imem_instr(imem_a),
    .ifid_valid(v_a), .ifid_instr(instr_a), .ifid_pc_plus4(pp4_a),
    .addr_err(err_a), .fetch_count(cnt_a)
  );

  fetch_stage #(.IMEM_WORDS(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .jump_valid(jump_valid), .jump_index(jump_index),
    .imem_pc(pc_b), .imem_instr(imem_b),
    .ifid_valid(v_b), .ifid_instr(instr_b), .ifid_pc_plus4(pp4_b),
    .addr_err(err_b), .fetch_count(cnt_b)
  );

  function automatic mstate_t mreset();
    mstate_t s;
    s.pc = 32'd0; s.v = 1'b0; s.instr = 32'd0; s.pp4 = 32'd0; s.err = 1'b0; s.cnt = 32'd0;
    return s;
  endfunction

  // One rising edge of the fetch stage, straight from the priority rules
  function automatic mstate_t mstep(input mstate_t s, input logic st, input logic rv,
                                    input logic [31:0] rpc, input logic jv, input logic [25:0] ji,
                                    input longint words, input int cw);
    mstate_t n;
    longint  cmax;
    n = s;
    n.err = 1'b0;
    cmax = (longint'(1) << cw) - 1;
    if (rv) begin
      n.pc = rpc - (rpc % 4);
      n.v = 1'b0; n.instr = 32'd0;
      n.err = (rpc % 4) != 0;
    end else if (jv && !st) begin
      n.pc = (s.pp4 & 32'hF000_0000) + {4'd0, ji, 2'd0};
      n.v = 1'b0; n.instr = 32'd0;
    end else if (!st) begin
      n.pc = s.pc + 32'd4;
      n.pp4 = s.pc + 32'd4;
      if (longint'(s.pc) < words * 4) begin
        n.v = 1'b1; n.instr = mem_word(s.pc);
        if (longint'(s.cnt) < cmax) n.cnt = s.cnt + 1;
      end else begin
        n.v = 1'b0; n.instr = 32'd0; n.err = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("a.pc", pc_a, ma.pc);
    chk("a.valid", 32'(v_a), 32'(ma.v));
    chk("a.instr", instr_a, ma.instr);
    chk("a.pc_plus4", pp4_a, ma.pp4);
    chk("a.addr_err", 32'(err_a), 32'(ma.err));
    chk("a.count", cnt_a, ma.cnt);
    chk("b.pc", pc_b, mb.pc);
    chk("b.valid", 32'(v_b), 32'(mb.v));
    chk("b.instr", instr_b, mb.instr);
    chk("b.pc_plus4", pp4_b, mb.pp4);
    chk("b.addr_err", 32'(err_b), 32'(mb.err));
    chk("b.count", 32'(cnt_b), mb.cnt);
  endtask

  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic jv, input logic [25:0] ji);
    stall = st; redirect_valid = rv; redirect_pc = rpc; jump_valid = jv; jump_index = ji;
    @(posedge clk);
    ma = mstep(ma, st, rv, rpc, jv, ji, 256, 32);
    mb = mstep(mb, st, rv, rpc, jv, ji, 4, 3);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; jump_valid = 1'b0;
    repeat (2) @(posedge clk);
    ma = mreset(); mb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //          st    rv    rpc       jv    ji        pc        v     instr          pp4       err   cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h04, 1'b1, 32'h8c010004, 32'h04, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h08, 1'b1, 32'h8c02000c, 32'h08, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 26'h0,  32'h08, 1'b1, 32'h8c02000c, 32'h08, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 26'h0,  32'h08, 1'b1, 32'h8c02000c, 32'h08, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h0c, 1'b1, 32'h8c030014, 32'h0c, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h10, 1'b1, 32'h8c04001c, 32'h10, 1'b0, 32'd4};
    vecs[6]  = '{1'b1, 1'b1, 32'h2c, 1'b0, 26'h0,  32'h2c, 1'b0, 32'h0,        32'h10, 1'b0, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h30, 1'b1, 32'h8c0c005c, 32'h30, 1'b0, 32'd5};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 26'h13, 32'h4c, 1'b0, 32'h0,        32'h30, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 26'h13, 32'h10, 1'b0, 32'h0,        32'h30, 1'b0, 32'd5};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h14, 1'b1, 32'h8c050024, 32'h14, 1'b0, 32'd6};
    vecs[11] = '{1'b0, 1'b1, 32'h33, 1'b0, 26'h0,  32'h30, 1'b0, 32'h0,        32'h14, 1'b1, 32'd6};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h34, 1'b1, 32'h8c0d0064, 32'h34, 1'b0, 32'd7};
    vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 26'h20, 32'h34, 1'b1, 32'h8c0d0064, 32'h34, 1'b0, 32'd7};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 26'h20, 32'h80, 1'b0, 32'h0,        32'h34, 1'b0, 32'd7};

    do_reset();
    #1;
    chk("reset.pc", pc_a, 32'h0);
    chk("reset.valid", 32'(v_a), 32'h0);
    chk("reset.instr", instr_a, 32'h0);
    chk("reset.pc_plus4", pp4_a, 32'h0);
    chk("reset.addr_err", 32'(err_a), 32'h0);
    chk("reset.count", cnt_a, 32'h0);

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].jv, vecs[i].ji);
      chk($sformatf("vec%0d.pc", i), pc_a, vecs[i].pc);
      chk($sformatf("vec%0d.valid", i), 32'(v_a), 32'(vecs[i].v));
      chk($sformatf("vec%0d.instr", i), instr_a, vecs[i].instr);
      chk($sformatf("vec%0d.pc_plus4", i), pp4_a, vecs[i].pp4);
      chk($sformatf("vec%0d.addr_err", i), 32'(err_a), 32'(vecs[i].err));
      chk($sformatf("vec%0d.count", i), cnt_a, vecs[i].cnt);
    end

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 32'($urandom_range(0, 'h41f)),
            $urandom_range(0, 5) == 0, 26'($urandom_range(0, 'h120)));
    end

    // Async reset asserted mid-cycle while stall and redirect are both active
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 26'h0);
    @(posedge clk);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async.a.pc", pc_a, 32'h0);
    chk("async.a.valid", 32'(v_a), 32'h0);
    chk("async.b.pc", pc_b, 32'h0);
    chk("async.a.count", cnt_a, 32'h0);
    @(posedge clk);
    ma = mreset(); mb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async.hold.pc", pc_a, 32'h0);

    // Small memory: fetch past the end, then saturate the 3-bit counter
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("small.count4", 32'(cnt_b), 32'd4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("small.oor.pc", pc_b, 32'h14);
    chk("small.oor.valid", 32'(v_b), 32'h0);
    chk("small.oor.err", 32'(err_b), 32'h1);
    chk("small.oor.pp4", pp4_b, 32'h14);
    chk("big.inrange.valid", 32'(v_a), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 26'h0);
    chk("redirect.err_clear", 32'(err_b), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("small.saturate", 32'(cnt_b), 32'd7);
    chk("big.count10", cnt_a, 32'd10);

    // PC wraps from the top of the address space to zero
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("wrap.pc", pc_a, 32'h0);
    chk("wrap.valid", 32'(v_a), 32'h0);
    chk("wrap.err", 32'(err_a), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("wrap.refetch", instr_a, 32'h8c010004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
